// File: rtl/bouncing_box_renderer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bouncing_box_renderer
//
// Pixel-stage renderer placed directly after a VGA sync generator. It draws a
// solid square that bounces around the active area, recolours on every wall
// hit, and paints a white 1-pixel border around the visible region. Colour and
// sync outputs are registered together so they stay aligned (1 clk latency).
//
// Ports:
//   clk                  pixel clock
//   reset                synchronous, active-high reset
//   enable               1 = box moves, 0 = box frozen (rendering continues)
//   h_count, v_count     current pixel column / line from the sync generator
//   display_en           high inside the active area
//   hsync_in, vsync_in   sync pulses from the sync generator
//   red, green, blue     registered 1-bit colour channels
//   hsync_out, vsync_out sync inputs delayed by 1 clk
//   frame_tick           1-clk pulse at the start of vertical blanking
//   box_x, box_y         current box left / top edge
// -----------------------------------------------------------------------------
module bouncing_box_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 50,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       display_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  // Position arithmetic is 11 bits wide so pos + STEP never wraps.
  localparam logic [10:0] XMAX     = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YMAX     = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] SIZE_W   = 11'(BOX_SIZE);
  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_SOF    = 10'(V_ACTIVE);
  localparam int          CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    MOVE_X,
    MOVE_Y,
    RECOLOR
  } state_t;

  // Result of advancing one axis by one step.
  typedef struct packed {
    logic [10:0] pos;
    logic        dir_pos;  // 1 = moving toward larger coordinates
    logic        hit;      // wall reached on this step
  } axis_t;

  function automatic axis_t step_axis(input logic [10:0] pos,
                                      input logic        dir_pos,
                                      input logic [10:0] lim);
    axis_t res;
    res.pos     = pos;
    res.dir_pos = dir_pos;
    res.hit     = 1'b0;
    if (dir_pos) begin
      if (pos + STEP_W >= lim) begin
        res.pos     = lim;
        res.dir_pos = 1'b0;
        res.hit     = 1'b1;
      end else begin
        res.pos = pos + STEP_W;
      end
    end else begin
      if (pos <= STEP_W) begin
        res.pos     = '0;
        res.dir_pos = 1'b1;
        res.hit     = 1'b1;
      end else begin
        res.pos = pos - STEP_W;
      end
    end
    return res;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [10:0]      r_x;
  logic [10:0]      r_y;
  logic             r_dir_x;
  logic             r_dir_y;
  logic [2:0]       r_colour;
  logic             r_bounce;
  logic [CNT_W-1:0] r_frame_cnt;

  logic [10:0] w_h;
  logic [10:0] w_v;
  logic        w_in_box;
  logic        w_border;
  logic        w_sof;
  logic [2:0]  w_rgb;
  axis_t       w_step_x;
  axis_t       w_step_y;

  assign w_h = {1'b0, h_count};
  assign w_v = {1'b0, v_count};

  assign w_in_box = display_en &&
                    (w_h >= r_x) && (w_h < r_x + SIZE_W) &&
                    (w_v >= r_y) && (w_v < r_y + SIZE_W);
  assign w_border = display_en &&
                    (h_count == '0 || h_count == H_LAST ||
                     v_count == '0 || v_count == V_LAST);
  // First blanking line: position updates land here, never mid-picture.
  assign w_sof    = (h_count == '0) && (v_count == V_SOF);

  assign w_rgb    = w_in_box ? r_colour : (w_border ? 3'b111 : 3'b000);
  assign w_step_x = step_axis(r_x, r_dir_x, XMAX);
  assign w_step_y = step_axis(r_y, r_dir_y, YMAX);

  assign box_x = r_x[9:0];
  assign box_y = r_y[9:0];

  // Pixel and sync pipeline stage.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      {red, green, blue} <= 3'b000;
      hsync_out          <= 1'b0;
      vsync_out          <= 1'b0;
      frame_tick         <= 1'b0;
    end else begin
      {red, green, blue} <= w_rgb;
      hsync_out          <= hsync_in;
      vsync_out          <= vsync_in;
      frame_tick         <= w_sof;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_FRAME;
    else       r_state <= w_next_state;
  end

  // NOTE: the default at the top of the block keeps every path assigned, so
  // no latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      WAIT_FRAME: if (w_sof && enable && r_frame_cnt == CNT_LAST) w_next_state = MOVE_X;
      MOVE_X:     w_next_state = MOVE_Y;
      MOVE_Y:     w_next_state = RECOLOR;
      RECOLOR:    w_next_state = WAIT_FRAME;
      default:    w_next_state = WAIT_FRAME;
    endcase
  end

  // Motion datapath, sequenced by the FSM one axis per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= 11'(INIT_X);
      r_y         <= 11'(INIT_Y);
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_colour    <= 3'b001;
      r_bounce    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      unique case (r_state)
        WAIT_FRAME: begin
          // Disabled frames leave the divider untouched.
          if (w_sof && enable)
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
        end
        MOVE_X: begin
          r_x     <= w_step_x.pos;
          r_dir_x <= w_step_x.dir_pos;
          if (w_step_x.hit) r_bounce <= 1'b1;
        end
        MOVE_Y: begin
          r_y     <= w_step_y.pos;
          r_dir_y <= w_step_y.dir_pos;
          if (w_step_y.hit) r_bounce <= 1'b1;
        end
        RECOLOR: begin
          // A corner hit sets the flag twice but recolours once; 000 is skipped.
          if (r_bounce)
            r_colour <= (r_colour == 3'b111) ? 3'b001 : r_colour + 3'd1;
          r_bounce <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bouncing_box_renderer.sv
`timescale 1ns/1ps
module tb_bouncing_box_renderer;

  localparam int NUM_RAND_FRAMES = 2000;
  localparam int XLIM = 640 - 32;
  localparam int YLIM = 480 - 32;
  localparam int P_INIT_X [2] = '{100, 607};
  localparam int P_INIT_Y [2] = '{50, 447};
  localparam int P_DIV    [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, display_en, hsync_in, vsync_in;
  logic [9:0] h_count, v_count;

  logic       red_a, green_a, blue_a, hs_a, vs_a, ft_a;
  logic [9:0] bx_a, by_a;
  logic       red_c, green_c, blue_c, hs_c, vs_c, ft_c;
  logic [9:0] bx_c, by_c;
  logic [2:0] rgb_a, rgb_c;
  assign rgb_a = {red_a, green_a, blue_a};
  assign rgb_c = {red_c, green_c, blue_c};

  bouncing_box_renderer dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync_out(hs_a), .vsync_out(vs_a), .frame_tick(ft_a),
    .box_x(bx_a), .box_y(by_a)
  );

  bouncing_box_renderer #(.INIT_X(607), .INIT_Y(447), .FRAME_DIV(3)) dut_c (
    .clk(clk), .reset(reset), .enable(enable),
    .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red_c), .green(green_c), .blue(blue_c),
    .hsync_out(hs_c), .vsync_out(vs_c), .frame_tick(ft_c),
    .box_x(bx_c), .box_y(by_c)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks_a = 0;

  // Reference model: box state per instance, plain integer arithmetic.
  int m_x [2];
  int m_y [2];
  int m_dx [2];
  int m_dy [2];
  int m_col [2];
  int m_cnt [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input int k);
    m_x[k]   = P_INIT_X[k];
    m_y[k]   = P_INIT_Y[k];
    m_dx[k]  = 1;
    m_dy[k]  = 1;
    m_col[k] = 1;
    m_cnt[k] = 0;
  endfunction

  function automatic void move_axis(inout int p, inout int d, input int lim, inout bit hit);
    int target;
    target = p + d * 2;
    if (d > 0 && target >= lim) begin
      p = lim; d = -1; hit = 1'b1;
    end else if (d < 0 && p <= 2) begin
      p = 0; d = 1; hit = 1'b1;
    end else begin
      p = target;
    end
  endfunction

  function automatic void model_frame(input int k);
    bit hit;
    m_cnt[k]++;
    if (m_cnt[k] < P_DIV[k]) return;
    m_cnt[k] = 0;
    hit = 1'b0;
    move_axis(m_x[k], m_dx[k], XLIM, hit);
    move_axis(m_y[k], m_dy[k], YLIM, hit);
    if (hit) m_col[k] = m_col[k] % 7 + 1;  // cycles 1..7, never 0
  endfunction

  function automatic int exp_rgb(input int k, input int hh, input int vv, input bit de);
    if (!de) return 0;
    if (hh >= m_x[k] && hh < m_x[k] + 32 && vv >= m_y[k] && vv < m_y[k] + 32)
      return m_col[k];
    if (hh == 0 || hh == 639 || vv == 0 || vv == 479) return 7;
    return 0;
  endfunction

  // One clock: randomise syncs, predict, clock, compare, advance model.
  task automatic tick();
    int  e_a, e_c;
    bit  e_sof;
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    e_sof = (h_count == 10'd0 && v_count == 10'd480);
    e_a = reset ? 0 : exp_rgb(0, int'(h_count), int'(v_count), display_en);
    e_c = reset ? 0 : exp_rgb(1, int'(h_count), int'(v_count), display_en);
    @(posedge clk);
    #1;
    check("rgb_a", int'(rgb_a), e_a);
    check("rgb_c", int'(rgb_c), e_c);
    check("frame_tick", int'(ft_a), int'(!reset && e_sof));
    check("frame_tick_c", int'(ft_c), int'(!reset && e_sof));
    check("hsync_out", int'(hs_a), int'(!reset && hsync_in));
    check("vsync_out", int'(vs_a), int'(!reset && vsync_in));
    if (ft_a) n_ticks_a++;
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else if (e_sof && enable) begin
      model_frame(0);
      model_frame(1);
    end
  endtask

  task automatic pixel(input int hh, input int vv, input bit de);
    h_count    = 10'(hh);
    v_count    = 10'(vv);
    display_en = de;
    tick();
  endtask

  // Condensed frame: SOF, blanking while the FSM updates, then probe pixels.
  task automatic frame(input bit en);
    int hh, vv;
    enable = en;
    pixel(0, 480, 1'b0);
    for (int i = 1; i <= 4; i++) pixel(i, 480, 1'b0);
    check("box_x_a", int'(bx_a), m_x[0]);
    check("box_y_a", int'(by_a), m_y[0]);
    check("box_x_c", int'(bx_c), m_x[1]);
    check("box_y_c", int'(by_c), m_y[1]);
    pixel(m_x[0], m_y[0], 1'b1);
    pixel(m_x[1] + 31, m_y[1] + 31, 1'b1);
    hh = m_x[0] + $urandom_range(0, 40) - 4;
    vv = m_y[0] + $urandom_range(0, 40) - 4;
    if (hh < 0) hh = 0;
    if (vv < 0) vv = 0;
    if (vv > 479) vv = 479;
    pixel(hh, vv, 1'($urandom_range(0, 7) != 0));
    pixel($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0));
  endtask

  initial begin
    int n0;
    reset = 1'b1; enable = 1'b0; display_en = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    h_count = '0; v_count = '0;
    model_reset(0);
    model_reset(1);
    tick();
    tick();
    reset = 1'b0;

    // Reset state and basic rendering.
    check("reset_box_x", int'(bx_a), 100);
    check("reset_box_y", int'(by_a), 50);
    pixel(100, 50, 1'b1);
    check("box_top_left", int'(rgb_a), 1);
    pixel(99, 50, 1'b1);
    check("left_of_box", int'(rgb_a), 0);
    pixel(0, 200, 1'b1);
    check("border_left", int'(rgb_a), 7);
    pixel(0, 200, 1'b0);
    check("blank_border", int'(rgb_a), 0);
    pixel(131, 81, 1'b1);
    check("box_bot_right", int'(rgb_a), 1);
    pixel(132, 81, 1'b1);
    check("right_of_box", int'(rgb_a), 0);

    // Three moving frames: main box steps diagonally, divided box moves once
    // on the third frame and hits the corner.
    frame(1'b1);
    check("div_hold_1", int'(bx_c), 607);
    frame(1'b1);
    check("div_hold_2", int'(bx_c), 607);
    frame(1'b1);
    check("motion_x", int'(bx_a), 106);
    check("motion_y", int'(by_a), 56);
    pixel(106, 56, 1'b1);
    check("motion_colour", int'(rgb_a), 1);
    check("corner_x", int'(bx_c), 608);
    check("corner_y", int'(by_c), 448);
    pixel(608, 448, 1'b1);
    check("corner_colour", int'(rgb_c), 2);

    // Frozen while disabled, frame ticks keep coming.
    n0 = n_ticks_a;
    for (int i = 0; i < 5; i++) frame(1'b0);
    check("ticks_disabled", n_ticks_a - n0, 5);
    check("frozen_x", int'(bx_a), 106);
    check("frozen_y", int'(by_a), 56);
    check("frozen_x_c", int'(bx_c), 608);

    // Long randomised run: many wall and corner bounces, colour wraps.
    for (int i = 0; i < NUM_RAND_FRAMES; i++)
      frame(1'($urandom_range(0, 9) != 0));

    // Reset mid-picture over the box.
    reset = 1'b1;
    pixel(m_x[0] + 1, m_y[0] + 1, 1'b1);
    check("reset_black", int'(rgb_a), 0);
    reset = 1'b0;
    check("rst_box_x", int'(bx_a), 100);
    check("rst_box_y", int'(by_a), 50);
    pixel(100, 50, 1'b1);
    check("rst_colour", int'(rgb_a), 1);
    frame(1'b1);
    check("rst_motion_x", int'(bx_a), 102);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bouncing_box_renderer.md
Name: bouncing_box_renderer

Overview:
Pixel-stage renderer that sits directly downstream of the VGA sync generator. It consumes the pixel counters and display enable, and drives the 1-bit red, green and blue channels. It draws a solid square that bounces around the active area, changes colour on each wall hit, and has a white 1-pixel border. Sync signals pass through a 1-cycle delay so they stay aligned with the registered colour outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, box edge length in pixels
STEP, 2, pixels moved per axis per update (1..BOX_SIZE)
INIT_X, 100, box left edge after reset
INIT_Y, 50, box top edge after reset
FRAME_DIV, 1, number of frames per position update (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = box moves; 0 = box frozen (rendering continues)
h_count  in  10  current pixel column from sync generator
v_count  in  10  current line from sync generator
display_en  in  1  high inside the active area
hsync_in  in  1  h_sync from sync generator
vsync_in  in  1  v_sync from sync generator
red  out  1  registered red channel
green  out  1  registered green channel
blue  out  1  registered blue channel
hsync_out  out  1  hsync_in delayed 1 clk
vsync_out  out  1  vsync_in delayed 1 clk
frame_tick  out  1  1-cycle pulse, once per frame
box_x  out  10  current box left edge
box_y  out  10  current box top edge

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, named reset.
- Reset values: red/green/blue/hsync_out/vsync_out/frame_tick = 0; box_x = INIT_X; box_y = INIT_Y; dir_x = dir_y = +; colour = 3'b001 (blue only); FSM = WAIT_FRAME; frame counter = 0.
- Reset mid-frame: outputs are black on the cycle after reset is sampled. Motion restarts from INIT_X/INIT_Y.
- Pixel path, latency 1 clk. Registered from the inputs of cycle N and visible in cycle N+1:
  - in_box = display_en && box_x <= h_count < box_x+BOX_SIZE && box_y <= v_count < box_y+BOX_SIZE.
  - border = display_en && (h_count==0 || h_count==H_ACTIVE-1 || v_count==0 || v_count==V_ACTIVE-1).
  - {red,green,blue} = in_box ? colour : border ? 3'b111 : 3'b000. The box takes priority over the border.
  - When display_en = 0, the output is always 3'b000.
- hsync_out and vsync_out are single-register delays of hsync_in and vsync_in.
- Frame detect: sof = (h_count==0 && v_count==V_ACTIVE), i.e. the first blanking line. frame_tick is sof registered: high for exactly 1 clk per frame.
- FSM states:
  - WAIT_FRAME: on sof, if enable=1 and frame counter == FRAME_DIV-1, clear the counter and go to MOVE_X. Otherwise, if sof, increment the counter and stay.
  - MOVE_X (1 clk), with XMAX = H_ACTIVE-BOX_SIZE:
    - dir + : if box_x+STEP >= XMAX, then box_x = XMAX, dir_x = -, bounce flag set. Else box_x += STEP.
    - dir - : if box_x <= STEP, then box_x = 0, dir_x = +, bounce flag set. Else box_x -= STEP.
  - MOVE_Y (1 clk): same rules with V_ACTIVE and box_y.
  - RECOLOR (1 clk): if the bounce flag is set, colour = colour+1, with 3'b111 wrapping to 3'b001 (000 is never produced). Clear the bounce flag and return to WAIT_FRAME.
- Updates land during vertical blanking, so the box never tears within a visible frame.
- Corner hit (both axes bounce in the same update): colour advances exactly once.
- enable=0: the FSM stays in WAIT_FRAME, the counter holds, and position, direction and colour are frozen. frame_tick still pulses.
- All position arithmetic is 11-bit internally, so box_x+STEP cannot overflow. box_x is always in [0, XMAX] and box_y in [0, V_ACTIVE-BOX_SIZE].

Test Plan:
- Reset with defaults, then drive h=100,v=50,display_en=1 -> next cycle rgb=001; h=99,v=50 -> rgb=000; h=0,v=200 -> rgb=111; display_en=0 at h=0 -> rgb=000.
- Latency: toggle hsync_in and vsync_in -> outputs follow exactly 1 clk later; sof at h=0,v=480 -> frame_tick high for 1 clk only.
- Motion: enable=1, FRAME_DIV=1, STEP=2, run 3 frames -> box_x=106, box_y=56, colour unchanged 001.
- Right wall: INIT_X=606, run 1 frame -> box_x=608 (XMAX), dir_x=-, colour=010. Next frame -> box_x=606.
- Corner: INIT_X=607, INIT_Y=447 -> one frame gives box_x=608, box_y=448, colour advances once (001->010). Colour sequence 111 -> 001 verified over 7 bounces.
- enable=0 for 5 frames -> box_x/box_y/colour constant while frame_tick pulses 5 times. FRAME_DIV=3 with enable=1 -> position changes only on every 3rd tick. Reset asserted mid-frame -> position returns to 100/50 and rgb=000 next cycle.
